// File: rtl/axil_reg_if_rd_buf.sv
// AXI4-Lite read slave bridging to a simple register-read port, with a timeout
// on each register access and a small FIFO of completed read responses.
module axil_reg_if_rd_buf #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT     = 4,
  parameter int TIMEOUT_ERR = 1,
  parameter int RESP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic [2:0]            reg_rd_prot,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack,
  output logic                  timeout_event
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready, and rdata/rresp hold steady while rvalid && !rready.

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

  localparam logic IDLE   = 1'b0;
  localparam logic ACCESS = 1'b1;

  logic                  state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            prot_q, prot_d;
  logic                  to_evt_q, to_evt_d;

  logic [EW-1:0]         mem_q [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;

  logic                  ar_hs, done, timed_out, push, pop;
  logic [1:0]            resp_in;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign s_axil_arready = (state_q == IDLE) && (count_q < DEPTH_C);
  assign ar_hs          = s_axil_arvalid && s_axil_arready;

  // An ack on the last counted cycle wins over the timeout.
  assign done      = (state_q == ACCESS) && (reg_rd_ack || (cnt_q == '0));
  assign timed_out = done && !reg_rd_ack;
  assign resp_in   = (timed_out && (TIMEOUT_ERR != 0)) ? 2'b10 : 2'b00;
  assign push      = done;
  assign pop       = s_axil_rvalid && s_axil_rready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    addr_d   = addr_q;
    prot_d   = prot_q;
    to_evt_d = timed_out;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          addr_d  = s_axil_araddr;
          prot_d  = s_axil_arprot;
          cnt_d   = TO_LOAD;
          en_d    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (done) begin
          en_d    = 1'b0;
          state_d = IDLE;
        end else if (!reg_rd_wait && (cnt_q != '0)) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      prot_q   <= '0;
      to_evt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      prot_q   <= prot_d;
      to_evt_q <= to_evt_d;
    end
  end

  // Space is reserved at AR acceptance, so a push never meets a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RESP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {reg_rd_data, resp_in};
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign s_axil_rvalid = (count_q != '0);
  assign s_axil_rdata  = mem_q[rd_ptr_q][EW-1:2];
  assign s_axil_rresp  = mem_q[rd_ptr_q][1:0];
  assign reg_rd_addr   = addr_q;
  assign reg_rd_prot   = prot_q;
  assign reg_rd_en     = en_q;
  assign timeout_event = to_evt_q;

endmodule

// File: tb/tb_axil_reg_if_rd_buf.sv
// Directed bench for axil_reg_if_rd_buf: latency, timeout, wait, backpressure,
// simultaneous push/pop and mid-access reset, checked against hand-computed values.
module tb_axil_reg_if_rd_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic [31:0] reg_rd_addr;
  logic [2:0]  reg_rd_prot;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_wait;
  logic        reg_rd_ack;
  logic        timeout_event;

  logic        ok_arready, ok_rvalid, ok_en, ok_evt;
  logic [31:0] ok_rdata, ok_addr;
  logic [1:0]  ok_rresp;
  logic [2:0]  ok_prot;

  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          n_en;

  always #5 clk = ~clk;

  axil_reg_if_rd_buf u_dut (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_rd_addr(reg_rd_addr), .reg_rd_prot(reg_rd_prot), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack),
    .timeout_event(timeout_event)
  );

  axil_reg_if_rd_buf #(.TIMEOUT_ERR(0)) u_dut_ok (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(ok_arready),
    .s_axil_rdata(ok_rdata), .s_axil_rresp(ok_rresp),
    .s_axil_rvalid(ok_rvalid), .s_axil_rready(s_axil_rready),
    .reg_rd_addr(ok_addr), .reg_rd_prot(ok_prot), .reg_rd_en(ok_en),
    .reg_rd_data(reg_rd_data), .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack),
    .timeout_event(ok_evt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first ACCESS cycle (handshake edge just passed).
  task automatic do_ar(input logic [31:0] addr, input logic [2:0] prot);
    int b;
    b = 0;
    while (!s_axil_arready && b < 50) begin
      step();
      b++;
    end
    if (b >= 50) chk("ar_wait", {63'd0, s_axil_arready}, 64'd1);
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = addr;
    s_axil_arprot  = prot;
    step();
    s_axil_arvalid = 1'b0;
  endtask

  task automatic rd_ack(input logic [31:0] data);
    reg_rd_ack  = 1'b1;
    reg_rd_data = data;
    exp_q.push_back(data);
    step();
    reg_rd_ack  = 1'b0;
  endtask

  task automatic drain(input int n_exp);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    s_axil_rready = 1'b1;
    while (s_axil_rvalid && cyc < 20) begin
      chk("drain_data", {32'd0, s_axil_rdata}, {32'd0, exp_q.pop_front()});
      got++;
      step();
      cyc++;
    end
    s_axil_rready = 1'b0;
    chk("drain_count", 64'(got), 64'(n_exp));
  endtask

  initial begin
    rst = 1'b1;
    s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0; reg_rd_data = '0; reg_rd_wait = 1'b0; reg_rd_ack = 1'b0;
    repeat (3) step();
    chk("rst_arready", {63'd0, s_axil_arready}, 64'd1);
    chk("rst_rvalid",  {63'd0, s_axil_rvalid}, 64'd0);
    chk("rst_en",      {63'd0, reg_rd_en}, 64'd0);
    chk("rst_addr",    {32'd0, reg_rd_addr}, 64'd0);
    chk("rst_rdata",   {30'd0, s_axil_rdata, s_axil_rresp}, 64'd0);
    chk("rst_evt",     {63'd0, timeout_event}, 64'd0);
    rst = 1'b0;
    step();

    // Ack while idle must be ignored.
    reg_rd_ack = 1'b1; reg_rd_data = 32'h11111111;
    step(); step();
    reg_rd_ack = 1'b0;
    chk("idle_ack_rvalid", {63'd0, s_axil_rvalid}, 64'd0);

    // Single read, minimum latency.
    do_ar(32'h10, 3'd5);
    chk("t1_en",     {63'd0, reg_rd_en}, 64'd1);
    chk("t1_addr",   {32'd0, reg_rd_addr}, 64'h10);
    chk("t1_prot",   {61'd0, reg_rd_prot}, 64'd5);
    chk("t1_rv_n1",  {63'd0, s_axil_rvalid}, 64'd0);
    rd_ack(32'hDEADBEEF);
    chk("t1_rv_n2",  {63'd0, s_axil_rvalid}, 64'd1);
    chk("t1_rresp",  {62'd0, s_axil_rresp}, 64'd0);
    chk("t1_en_off", {63'd0, reg_rd_en}, 64'd0);
    drain(1);

    // Timeout without ack.
    reg_rd_data = 32'h5A5A0001;
    do_ar(32'h20, 3'd0);
    n_en = 0;
    while (reg_rd_en && n_en < 40) begin
      n_en++;
      step();
    end
    exp_q.push_back(32'h5A5A0001);
    chk("t2_en_cycles", 64'(n_en), 64'd4);
    chk("t2_evt",       {63'd0, timeout_event}, 64'd1);
    chk("t2_rresp_err", {62'd0, s_axil_rresp}, 64'd2);
    chk("t2_rresp_ok",  {62'd0, ok_rresp}, 64'd0);
    step();
    chk("t2_evt_once",  {63'd0, timeout_event}, 64'd0);
    drain(1);

    // Wait held 10 cycles then released.
    reg_rd_data = 32'h5A5A0002;
    do_ar(32'h24, 3'd0);
    reg_rd_wait = 1'b1;
    n_en = 0;
    while (reg_rd_en && n_en < 40) begin
      if (n_en == 10) reg_rd_wait = 1'b0;
      n_en++;
      step();
    end
    reg_rd_wait = 1'b0;
    exp_q.push_back(32'h5A5A0002);
    chk("t3_en_cycles", 64'(n_en), 64'd14);
    chk("t3_rresp",     {62'd0, s_axil_rresp}, 64'd2);
    drain(1);

    // Six back-to-back reads against a stalled response channel.
    for (int i = 0; i < 4; i++) begin
      do_ar(32'h100 + i, 3'd0);
      rd_ack(32'hA0 + i);
    end
    chk("t4_arready_full", {63'd0, s_axil_arready}, 64'd0);
    step(); step();
    chk("t4_head_stable", {32'd0, s_axil_rdata}, 64'hA0);
    s_axil_rready = 1'b1;
    fork
      begin
        for (int i = 4; i < 6; i++) begin
          do_ar(32'h100 + i, 3'd0);
          rd_ack(32'hA0 + i);
        end
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 200) begin
          if (s_axil_rvalid) begin
            chk("t4_order", {32'd0, s_axil_rdata}, {32'd0, exp_q.pop_front()});
            got++;
          end
          step();
          cyc++;
        end
        if (got < 6) chk("t4_got", 64'(got), 64'd6);
      end
    join
    s_axil_rready = 1'b0;
    step();
    chk("t4_empty", {63'd0, s_axil_rvalid}, 64'd0);

    // Push and pop in the same cycle.
    for (int i = 0; i < 3; i++) begin
      do_ar(32'h200 + i, 3'd0);
      rd_ack(32'hC0 + i);
    end
    do_ar(32'h203, 3'd0);
    chk("t5_head", {32'd0, s_axil_rdata}, {32'd0, exp_q.pop_front()});
    s_axil_rready = 1'b1;
    rd_ack(32'hC3);
    s_axil_rready = 1'b0;
    chk("t5_arready", {63'd0, s_axil_arready}, 64'd1);
    chk("t5_rvalid",  {63'd0, s_axil_rvalid}, 64'd1);
    drain(3);

    // Reset in the middle of an access with responses buffered.
    do_ar(32'h300, 3'd0); rd_ack(32'hE0);
    do_ar(32'h304, 3'd0); rd_ack(32'hE1);
    do_ar(32'h308, 3'd0);
    chk("t6_en_before", {63'd0, reg_rd_en}, 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_en",      {63'd0, reg_rd_en}, 64'd0);
    chk("t6_rvalid",  {63'd0, s_axil_rvalid}, 64'd0);
    chk("t6_arready", {63'd0, s_axil_arready}, 64'd1);
    step();
    rst = 1'b0;
    exp_q.delete();
    step();
    do_ar(32'h40, 3'd1);
    rd_ack(32'h12345678);
    chk("t6_rv_after", {63'd0, s_axil_rvalid}, 64'd1);
    chk("t6_rresp",    {62'd0, s_axil_rresp}, 64'd0);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
